// File: rtl/etapa_mem_if.sv
// Data-memory bus of the MEM stage.
//   mem_req   : stage -> memory, access in progress
//   mem_we    : stage -> memory, 1 = write, 0 = read
//   mem_addr  : stage -> memory, word address
//   mem_wdata : stage -> memory, write data
//   mem_rdata : memory -> stage, read data, valid with mem_ack
//   mem_ack   : memory -> stage, one-cycle completion pulse
// Handshake: the stage raises mem_req with mem_we/mem_addr/mem_wdata and keeps
// all four stable until the cycle in which mem_ack is sampled high. That cycle
// completes the access. mem_req then drops on the next cycle. An ack seen while
// mem_req is low has no meaning and is ignored.
interface etapa_mem_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/etapa_mem.sv
// etapa_mem: data-memory access stage between EX/MEM and MEM/WB.
// ALU results and write-back controls pass through with one cycle of latency.
// Loads and stores are latched, issued on the memory bus (etapa_mem_if), and
// stall upstream until mem_ack arrives.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_in, mem_rd_in, mem_wr_in, DATA_in, store_data_in, dir_dest_in,
//   data_wrs_in, sel_wb_in, reg_wrv_in, reg_wrs_in   EX/MEM contents
//   bus                memory bus (master side)
//   stall_out          freeze EX/MEM and earlier while an access is pending
//   MEM_out, DATA_out, dir_dest_out, data_wrs_out, sel_wb_out, reg_wrv_out,
//   reg_wrs_out        to MEM/WB
//   err_out            one-cycle pulse when an access is aborted
//   dbg_state          current state (0 = IDLE, 1 = WAIT)
// Optional feature: define MEM_TIMEOUT_EN to abort an access that sees no
// mem_ack within TIMEOUT cycles of WAIT. Without it WAIT lasts until ack and
// err_out stays 0.
module etapa_mem #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [31:0] DATA_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  dir_dest_in,
  input  logic [7:0]  data_wrs_in,
  input  logic        sel_wb_in,
  input  logic        reg_wrv_in,
  input  logic        reg_wrs_in,
  etapa_mem_if.master bus,
  output logic        stall_out,
  output logic [31:0] MEM_out,
  output logic [31:0] DATA_out,
  output logic [2:0]  dir_dest_out,
  output logic [7:0]  data_wrs_out,
  output logic        sel_wb_out,
  output logic        reg_wrv_out,
  output logic        reg_wrs_out,
  output logic        err_out,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state;

  // Latched memory instruction, held for the whole WAIT period.
  logic        we_q;
  logic [31:0] data_q;
  logic [31:0] sdata_q;
  logic [2:0]  dest_q;
  logic [7:0]  wrs_q;
  logic        sel_q;
  logic        wrv_q;
  logic        wrsc_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  wire in_wait = (state == WAIT);

  // All of these decode registered state only; nothing here sees an input.
  assign stall_out     = in_wait;
  assign dbg_state     = in_wait;
  assign bus.mem_req   = in_wait;
  assign bus.mem_we    = in_wait & we_q;
  assign bus.mem_addr  = in_wait ? data_q[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = in_wait ? sdata_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      data_q       <= '0;
      sdata_q      <= '0;
      dest_q       <= '0;
      wrs_q        <= '0;
      sel_q        <= 1'b0;
      wrv_q        <= 1'b0;
      wrsc_q       <= 1'b0;
      MEM_out      <= '0;
      DATA_out     <= '0;
      dir_dest_out <= '0;
      data_wrs_out <= '0;
      sel_wb_out   <= 1'b0;
      reg_wrv_out  <= 1'b0;
      reg_wrs_out  <= 1'b0;
      err_out      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // Every cycle is a bubble unless a branch below writes a result.
      MEM_out      <= '0;
      DATA_out     <= '0;
      dir_dest_out <= '0;
      data_wrs_out <= '0;
      sel_wb_out   <= 1'b0;
      reg_wrv_out  <= 1'b0;
      reg_wrs_out  <= 1'b0;
      err_out      <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_in) begin
            if (mem_rd_in || mem_wr_in) begin
              // rd+wr together is a store: we follows mem_wr_in alone.
              we_q    <= mem_wr_in;
              data_q  <= DATA_in;
              sdata_q <= store_data_in;
              dest_q  <= dir_dest_in;
              wrs_q   <= data_wrs_in;
              sel_q   <= sel_wb_in;
              wrv_q   <= reg_wrv_in;
              wrsc_q  <= reg_wrs_in;
              state   <= WAIT;
`ifdef MEM_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              DATA_out     <= DATA_in;
              dir_dest_out <= dir_dest_in;
              data_wrs_out <= data_wrs_in;
              sel_wb_out   <= sel_wb_in;
              reg_wrv_out  <= reg_wrv_in;
              reg_wrs_out  <= reg_wrs_in;
            end
          end
        end

        WAIT: begin
          // Ack wins over a timeout landing on the same cycle.
          if (bus.mem_ack) begin
            MEM_out      <= we_q ? 32'd0 : bus.mem_rdata;
            DATA_out     <= data_q;
            dir_dest_out <= dest_q;
            data_wrs_out <= wrs_q;
            sel_wb_out   <= sel_q;
            reg_wrv_out  <= wrv_q;
            reg_wrs_out  <= wrsc_q;
            state        <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            err_out <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_mem.sv
module tb_etapa_mem;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic        valid, rd, wr;
    logic [31:0] data, sdata;
    logic [2:0]  dest;
    logic [7:0]  wrs;
    logic        sel, wrv, wrsc;
  } instr_t;

  typedef struct {
    logic [31:0] mem, data;
    logic [2:0]  dest;
    logic [7:0]  wrs;
    logic        sel, wrv, wrsc, err;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in, mem_rd_in, mem_wr_in;
  logic [31:0] DATA_in, store_data_in;
  logic [2:0]  dir_dest_in;
  logic [7:0]  data_wrs_in;
  logic        sel_wb_in, reg_wrv_in, reg_wrs_in;
  logic        stall_out, err_out, dbg_state;
  logic [31:0] MEM_out, DATA_out;
  logic [2:0]  dir_dest_out;
  logic [7:0]  data_wrs_out;
  logic        sel_wb_out, reg_wrv_out, reg_wrs_out;

  etapa_mem_if #(.ADDR_W(ADDR_W)) bus ();

  etapa_mem #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .DATA_in(DATA_in), .store_data_in(store_data_in),
    .dir_dest_in(dir_dest_in), .data_wrs_in(data_wrs_in),
    .sel_wb_in(sel_wb_in), .reg_wrv_in(reg_wrv_in), .reg_wrs_in(reg_wrs_in),
    .bus(bus),
    .stall_out(stall_out), .MEM_out(MEM_out), .DATA_out(DATA_out),
    .dir_dest_out(dir_dest_out), .data_wrs_out(data_wrs_out),
    .sel_wb_out(sel_wb_out), .reg_wrv_out(reg_wrv_out), .reg_wrs_out(reg_wrs_out),
    .err_out(err_out), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [1024];   // contents of the memory the bench plays
  instr_t      prog_q[$];      // directed instructions, used before random ones
  int          delay_q[$];     // directed ack delays (WAIT cycles before ack)
  logic [31:0] exp_q[$];       // expected MEM_out of completed loads, in order

  bit     busy = 1'b0;         // a memory access is outstanding
  instr_t cur;
  int     waits, ack_delay;
  out_t   exp_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input instr_t t);
    valid_in      = t.valid;
    mem_rd_in     = t.rd;
    mem_wr_in     = t.wr;
    DATA_in       = t.data;
    store_data_in = t.sdata;
    dir_dest_in   = t.dest;
    data_wrs_in   = t.wrs;
    sel_wb_in     = t.sel;
    reg_wrv_in    = t.wrv;
    reg_wrs_in    = t.wrsc;
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    int kind;
    kind    = $urandom_range(0, 2);
    t.valid = ($urandom_range(0, 3) != 0);
    t.rd    = (kind == 1) || (kind == 2 && $urandom_range(0, 3) == 0);
    t.wr    = (kind == 2);
    // Upper bits random, word index kept small so loads hit earlier stores.
    t.data  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
    t.sdata = $urandom;
    t.dest  = 3'($urandom);
    t.wrs   = 8'($urandom);
    t.sel   = 1'($urandom);
    t.wrv   = 1'($urandom);
    t.wrsc  = 1'($urandom);
    return t;
  endfunction

  function automatic out_t result_of(input instr_t t, input logic [31:0] mem_val);
    out_t o;
    o.mem  = mem_val;
    o.data = t.data;
    o.dest = t.dest;
    o.wrs  = t.wrs;
    o.sel  = t.sel;
    o.wrv  = t.wrv;
    o.wrsc = t.wrsc;
    o.err  = 1'b0;
    return o;
  endfunction

  // Choose inputs for the next edge and what that edge must produce.
  task automatic plan();
    instr_t t;
    int idx;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    exp_o         = '{default: '0};
    if (!busy) begin
      t = (prog_q.size() != 0) ? prog_q.pop_front() : rand_instr();
      drive(t);
      bus.mem_ack = ($urandom_range(0, 3) == 0);   // stray ack, must be ignored
      if (t.valid && !t.rd && !t.wr) begin
        exp_o = result_of(t, 32'd0);
      end else if (t.valid) begin
        busy  = 1'b1;
        cur   = t;
        waits = 0;
        if (delay_q.size() != 0) ack_delay = delay_q.pop_front();
`ifdef MEM_TIMEOUT_EN
        else if ($urandom_range(0, 4) == 0) ack_delay = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
`endif
        else ack_delay = $urandom_range(0, 4);
      end
    end else begin
      idx = int'(cur.data[ADDR_W-1:0]);
      if (waits == ack_delay) begin
        bus.mem_ack = 1'b1;
        if (cur.wr) begin
          mem_m[idx] = cur.sdata;
          exp_o = result_of(cur, 32'd0);
        end else begin
          bus.mem_rdata = mem_m[idx];
          exp_o = result_of(cur, mem_m[idx]);
          exp_q.push_back(mem_m[idx]);
        end
        busy = 1'b0;
      end
`ifdef MEM_TIMEOUT_EN
      else if (waits == TIMEOUT - 1) begin
        exp_o.err = 1'b1;
        busy = 1'b0;
      end
`endif
      else begin
        waits++;
      end
    end
  endtask

  // Compare process body: outputs after an edge against the model.
  task automatic check_outputs();
    chk("MEM_out", MEM_out, exp_o.mem);
    chk("DATA_out", DATA_out, exp_o.data);
    chk("dir_dest_out", 32'(dir_dest_out), 32'(exp_o.dest));
    chk("data_wrs_out", 32'(data_wrs_out), 32'(exp_o.wrs));
    chk("sel_wb_out", 32'(sel_wb_out), 32'(exp_o.sel));
    chk("reg_wrv_out", 32'(reg_wrv_out), 32'(exp_o.wrv));
    chk("reg_wrs_out", 32'(reg_wrs_out), 32'(exp_o.wrsc));
    chk("err_out", 32'(err_out), 32'(exp_o.err));
    chk("stall_out", 32'(stall_out), 32'(busy));
    chk("mem_req", 32'(bus.mem_req), 32'(busy));
    chk("dbg_state", 32'(dbg_state), 32'(busy));
    if (busy) begin
      chk("mem_we", 32'(bus.mem_we), 32'(cur.wr));
      chk("mem_addr", 32'(bus.mem_addr), 32'(cur.data[ADDR_W-1:0]));
      chk("mem_wdata", bus.mem_wdata, cur.sdata);
    end
  endtask

  task automatic step();
    plan();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_err"}, 32'(err_out), 32'd0);
    chk({tag, "_MEM_out"}, MEM_out, 32'd0);
    chk({tag, "_DATA_out"}, DATA_out, 32'd0);
    chk({tag, "_ctrl"}, {19'd0, dir_dest_out, data_wrs_out, sel_wb_out, reg_wrv_out, reg_wrs_out}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  function automatic instr_t mk(input bit rd, input bit wr, input logic [31:0] data,
                                input logic [31:0] sdata, input logic [2:0] dest);
    instr_t t;
    t = '{valid: 1'b1, rd: rd, wr: wr, data: data, sdata: sdata, dest: dest,
          wrs: 8'h3C, sel: 1'b1, wrv: 1'b1, wrsc: 1'b1};
    return t;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    instr_t z;
    z = '{default: '0};
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
    drive(z);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    exp_o         = '{default: '0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // ALU passthrough
    prog_q.push_back(mk(1'b0, 1'b0, 32'h1234_5678, 32'h0, 3'd5));
    step();
    chk("lit_pass_DATA", DATA_out, 32'h1234_5678);
    chk("lit_pass_dest", 32'(dir_dest_out), 32'd5);
    chk("lit_pass_wrv", 32'(reg_wrv_out), 32'd1);
    chk("lit_pass_MEM", MEM_out, 32'd0);
    chk("lit_pass_stall", 32'(stall_out), 32'd0);

    // Load acked in the third WAIT cycle, then an ALU op held upstream
    mem_m[10'h040] = 32'hDEAD_BEEF;
    prog_q.push_back(mk(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'd2));
    prog_q.push_back(mk(1'b0, 1'b0, 32'h0BAD_F00D, 32'h0, 3'd6));
    delay_q.push_back(2);
    step();
    chk("lit_ld_addr", 32'(bus.mem_addr), 32'h040);
    chk("lit_ld_we", 32'(bus.mem_we), 32'd0);
    chk("lit_ld_stall1", 32'(stall_out), 32'd1);
    step();
    chk("lit_ld_stall2", 32'(stall_out), 32'd1);
    step();
    chk("lit_ld_stall3", 32'(stall_out), 32'd1);
    step();
    chk("lit_ld_MEM", MEM_out, 32'hDEAD_BEEF);
    chk("lit_ld_dest", 32'(dir_dest_out), 32'd2);
    chk("lit_ld_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("lit_alu_after_ld", DATA_out, 32'h0BAD_F00D);
    chk("lit_alu_after_ld_MEM", MEM_out, 32'd0);

    // Store with immediate ack
    prog_q.push_back(mk(1'b0, 1'b1, 32'h0000_0007, 32'hA5A5_0001, 3'd1));
    delay_q.push_back(0);
    step();
    chk("lit_st_we", 32'(bus.mem_we), 32'd1);
    chk("lit_st_wdata", bus.mem_wdata, 32'hA5A5_0001);
    step();
    chk("lit_st_MEM", MEM_out, 32'd0);
    chk("lit_st_stall", 32'(stall_out), 32'd0);
    chk("lit_st_mem", mem_m[7], 32'hA5A5_0001);

    // Reset in the middle of WAIT
    prog_q.push_back(mk(1'b1, 1'b0, 32'h0000_0003, 32'h0, 3'd4));
    delay_q.push_back(10);
    step();
    step();
    chk("lit_rst_pre_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midwait_reset");
    busy  = 1'b0;
    exp_o = '{default: '0};
    drive(z);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    repeat (3000) step();
    while (busy) step();   // bounded by ack_delay / timeout
    step();

    $display("loads completed: %0d", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/etapa_mem.md
Name: etapa_mem

Overview:
- Data-memory access stage of the vector pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Passes ALU results and write-back controls through in one cycle.
- Runs load/store accesses against a data memory over a req/ack handshake, stalling upstream until the access completes.
- Outputs feed registro_MEM_WB directly: MEM, DATA, dir_dest, data_wrs, sel_wb, reg_wrv, reg_wrs.

Parameters:
- ADDR_W, 10, data-memory word-address width; mem_addr = DATA_in[ADDR_W-1:0] (word addressed).
- TIMEOUT, 16, cycles waited in WAIT for mem_ack before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  EX/MEM holds a valid instruction.
- mem_rd_in  in  1  instruction is a load.
- mem_wr_in  in  1  instruction is a store.
- DATA_in  in  32  ALU result / effective address.
- store_data_in  in  32  store data.
- dir_dest_in  in  3  destination register.
- data_wrs_in  in  8  scalar write data.
- sel_wb_in, reg_wrv_in, reg_wrs_in  in  1 each  write-back controls.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- stall_out  out  1  freeze EX/MEM and earlier stages.
- MEM_out  out  32  load data.
- DATA_out  out  32  ALU result passthrough.
- dir_dest_out  out  3  destination register.
- data_wrs_out  out  8  scalar write data.
- sel_wb_out, reg_wrv_out, reg_wrs_out  out  1 each  write-back controls.
- err_out  out  1  one-cycle access-abort flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, stall_out, err_out and every *_out.
  - Latched request registers cleared.
  - Reset during WAIT abandons the access; mem_req drops immediately.
- States: IDLE, WAIT.
- stall_out = (state==WAIT), decoded from registered state only. No combinational path from any input.
- IDLE, valid_in=0: next posedge emits a bubble: reg_wrv_out=reg_wrs_out=sel_wb_out=0, other *_out=0.
- IDLE, valid_in=1, neither rd nor wr: next posedge copies every *_in to its *_out; MEM_out=0. Latency 1.
- IDLE, valid_in=1, rd or wr:
  - Latch DATA_in, store_data_in, dir_dest_in, data_wrs_in, controls, and we=mem_wr_in.
  - Go to WAIT and emit a bubble that cycle.
- rd and wr both set: treated as a store; MEM_out=0.
- WAIT:
  - mem_req=1; mem_we/mem_addr/mem_wdata driven from latched values and held stable until ack.
  - On mem_ack:
    - *_out load the latched values.
    - MEM_out = mem_rdata for a load, 0 for a store.
    - Go to IDLE; mem_req=0 next cycle.
  - Without ack: hold state, bubble outputs, stall held.
- Minimum memory-op latency: 2 cycles (ack in first WAIT cycle). mem_ack in IDLE is ignored.
- Upstream contract: EX/MEM holds its contents while stall_out=1. The instruction following a memory op is presented in IDLE after completion and processed normally.
- Back-to-back memory ops: each takes the full IDLE→WAIT→IDLE sequence; no overlap.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter cleared on WAIT entry, incremented each WAIT cycle without ack.
  - When count reaches TIMEOUT-1 with no ack: drop mem_req, return to IDLE, emit bubble (no register write), pulse err_out=1 for one cycle.
  - Ack on the final cycle takes priority over timeout.
- Undefined: no counter; WAIT persists until ack; err_out tied 0.

Test Plan:
- Reset mid-WAIT: rst_n low while mem_req=1 → mem_req, stall_out, all *_out = 0 immediately; state IDLE after release.
- ALU passthrough: valid_in=1, rd=wr=0, DATA_in=32'h1234_5678, dir_dest_in=3'd5, reg_wrv_in=1 → one posedge later DATA_out=32'h1234_5678, dir_dest_out=5, reg_wrv_out=1, MEM_out=0, stall_out=0.
- Load, ack after 3 cycles: DATA_in=32'h0000_0040, mem_rd_in=1 → mem_addr=10'h040, mem_we=0, stall_out high 3 cycles; ack with mem_rdata=32'hDEAD_BEEF → MEM_out=32'hDEAD_BEEF, controls restored, mem_req low next cycle.
- Store: mem_wr_in=1, store_data_in=32'hA5A5_0001, immediate ack → mem_we=1, mem_wdata=32'hA5A5_0001 for exactly 1 WAIT cycle; MEM_out=0; 2-cycle total.
- Load followed by ALU op held upstream → ALU result appears one cycle after load result; nothing dropped or duplicated.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack → mem_req high 4 cycles, then err_out=1 one cycle, reg_wrv_out=reg_wrs_out=0, stall_out=0.
